// File: rtl/input_cond_pkg.sv
// rtl/input_cond_pkg.sv - shared state encoding and defaults for the input conditioner
package input_cond_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHECK_HIGH  = 2'd1,
    STABLE_HIGH = 2'd2,
    CHECK_LOW   = 2'd3
  } debounce_state_e;

  // 10 ms at 100 MHz
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_CNT_WIDTH       = 20;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one channel: 2-flop synchronizer, debounce FSM, edge pulses
module debounce_channel
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rawIn,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam bit                   SINGLE   = (DEBOUNCE_CYCLES == 1);

  logic                 s1;
  logic                 s2;
  debounce_state_e      state;
  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= rawIn;
      s2 <= s1;
    end
  end

  // Any reversal during a CHECK state drops back to the stable state with cnt cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STABLE_LOW;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        STABLE_LOW: begin
          if (s2) begin
            if (SINGLE) begin
              state <= STABLE_HIGH;
              level <= 1'b1;
              rise  <= 1'b1;
            end else begin
              state <= CHECK_HIGH;
              cnt   <= CNT_ONE;
            end
          end
        end
        CHECK_HIGH: begin
          if (!s2) begin
            state <= STABLE_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_HIGH;
            cnt   <= '0;
            level <= 1'b1;
            rise  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STABLE_HIGH: begin
          if (!s2) begin
            if (SINGLE) begin
              state <= STABLE_LOW;
              level <= 1'b0;
              fall  <= 1'b1;
            end else begin
              state <= CHECK_LOW;
              cnt   <= CNT_ONE;
            end
          end
        end
        CHECK_LOW: begin
          if (s2) begin
            state <= STABLE_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_LOW;
            cnt   <= '0;
            level <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= STABLE_LOW;
          cnt   <= '0;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - two independent debounced channels feeding the AND gate stage
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rawInput1,
  input  logic rawInput2,
  output logic level1,
  output logic level2,
  output logic rise1,
  output logic rise2,
  output logic fall1,
  output logic fall2
);

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_ch1 (
    .clk  (clk),
    .rst_n(rst_n),
    .rawIn(rawInput1),
    .level(level1),
    .rise (rise1),
    .fall (fall1)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_ch2 (
    .clk  (clk),
    .rst_n(rst_n),
    .rawIn(rawInput2),
    .level(level2),
    .rise (rise2),
    .fall (fall2)
  );

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Two-channel input conditioner directly upstream of the 2-input AND gate stage.
- Takes two raw asynchronous board inputs (switches/buttons) and delivers clean, synchronized, debounced levels that drive the AND gate's input1/input2.
- Also emits single-cycle rise and fall pulses per channel for downstream counters and LEDs.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive clocks the synchronized input must hold a new value before the stable level changes (10 ms at 100 MHz); legal range ≥1.
- CNT_WIDTH, 20, debounce counter width; must satisfy 2^CNT_WIDTH ≥ DEBOUNCE_CYCLES.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rawInput1  input  1  raw asynchronous channel-1 input.
- rawInput2  input  1  raw asynchronous channel-2 input.
- level1  output  1  debounced channel-1 level, drives AND input1.
- level2  output  1  debounced channel-2 level, drives AND input2.
- rise1  output  1  one-cycle pulse when level1 goes 0→1.
- rise2  output  1  one-cycle pulse when level2 goes 0→1.
- fall1  output  1  one-cycle pulse when level1 goes 1→0.
- fall2  output  1  one-cycle pulse when level2 goes 1→0.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: while rst_n=0, every flop clears immediately regardless of clk.
  - Outputs: level=0, rise=0, fall=0.
  - Internal: sync flops=0, counter=0, state=STABLE_LOW.
- Reset mid-operation discards any partial debounce count.
- Channels are identical and fully independent; there is no cross-channel interaction.
- Synchronizer: 2-flop chain, raw → s1 → s2. Only s2 feeds the FSM.
- FSM states per channel: STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW.
- STABLE_LOW:
  - s2=0: stay.
  - s2=1 and DEBOUNCE_CYCLES=1: go to STABLE_HIGH, pulse rise.
  - s2=1 otherwise: go to CHECK_HIGH, cnt=1.
- CHECK_HIGH:
  - s2=0: back to STABLE_LOW, cnt=0, no pulse (glitch rejected).
  - s2=1 and cnt=DEBOUNCE_CYCLES-1: go to STABLE_HIGH, cnt=0, rise=1 for that cycle.
  - s2=1 otherwise: cnt+1.
- STABLE_HIGH and CHECK_LOW mirror the above with polarities swapped; they produce fall pulses.
- level is registered: it is 1 exactly in STABLE_HIGH and CHECK_LOW.
- rise and fall are registered and asserted for exactly one cycle, in the same cycle level changes.
- Latency: a raw change held steady appears on level exactly DEBOUNCE_CYCLES+2 rising edges after it, counting the first edge that samples the new value. The 2 edges are synchronizer latency.
- A pulse of s2 shorter than DEBOUNCE_CYCLES cycles produces no output change. The counter restarts from zero on every reversal.
- Counter never exceeds DEBOUNCE_CYCLES-1, so no wrap is possible.
- rise and fall of the same channel are never asserted together.
- Raw input already high at reset release: level rises DEBOUNCE_CYCLES+2 edges after release, with a rise pulse.

Decomposition:
- Shared package input_cond_pkg:
  - state enum {STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW} in 2 bits.
  - default DEBOUNCE_CYCLES and CNT_WIDTH constants.
- One sub-module, debounce_channel:
  - Contains the synchronizer, FSM and counter for a single channel.
  - Ports: clk, rst_n, rawIn, level, rise, fall.
- input_conditioner instantiates debounce_channel twice.

Test Plan (DEBOUNCE_CYCLES=4, CNT_WIDTH=3):
- Reset:
  - Stimulus: rst_n=0 for 3 cycles, raw inputs 0, then release and run 10 cycles.
  - Required: all six outputs 0 throughout.
- Clean rise:
  - Stimulus: rawInput1 0→1 and held.
  - Required: level1=1 from the 6th edge onward; rise1=1 for exactly that one cycle; fall1 stays 0; channel-2 outputs untouched.
- Glitch:
  - Stimulus: rawInput1 high for 3 cycles, then low.
  - Required: level1 stays 0 and no pulses. Then holding high 4+ cycles raises level1 at the 6th edge after the change.
- Simultaneous events:
  - Stimulus: level2=1 settled; in the same cycle rawInput1 0→1 and rawInput2 1→0.
  - Required: rise1 and fall2 both 1 in the same cycle, 6 edges later; level1=1, level2=0.
- Reset mid-check:
  - Stimulus: rawInput1 held high; assert rst_n=0 when the counter is 2; release after 2 cycles.
  - Required: outputs 0 immediately on assertion, before any clk edge. level1 rises 6 edges after release, with a rise1 pulse.
- High at release:
  - Stimulus: rawInput2=1 during reset.
  - Required: level2 rises with a rise2 pulse 6 edges after rst_n deasserts.
